tma_serial_add_ctrl: RTL and testbench

//  Sequencer that performs a WIDTH-bit addition by driving one external 2-bit mux-based adder slice.

---
 rtl/tma_serial_add_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tma_serial_add_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tma_serial_add_ctrl.sv
// Digit-serial adder sequencer: walks WIDTH-bit operands through one shared 2-bit adder slice,
// LSB digit first, holding each digit SETTLE cycles and chaining the slice carry in a register.
module tma_serial_add_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    output logic             slice_ci,
    input  logic [1:0]       slice_s,
    input  logic             slice_co
);

    localparam int NDIG = WIDTH / 2;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("tma_serial_add_ctrl: WIDTH must be even and >= 2");
        end
        if (SETTLE < 1) begin : g_bad_settle
            $error("tma_serial_add_ctrl: SETTLE must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [1:0]       slice_a_q, slice_a_d;
    logic [1:0]       slice_b_q, slice_b_d;
    logic             slice_ci_q, slice_ci_d;

    logic [1:0] a_dig [NDIG];
    logic [1:0] b_dig [NDIG];

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
            assign a_dig[gi] = a_q[2*gi +: 2];
            assign b_dig[gi] = b_q[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        slice_a_d  = slice_a_q;
        slice_b_d  = slice_b_q;
        slice_ci_d = slice_ci_q;

        case (state_q)
            S_IDLE: begin
                slice_a_d  = 2'b00;
                slice_b_d  = 2'b00;
                slice_ci_d = 1'b0;
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    // Digit 0 is loaded on the accept edge so the slice sees it for the full first RUN cycle.
                    slice_a_d  = a[1:0];
                    slice_b_d  = b[1:0];
                    slice_ci_d = cin;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNTW'(1);
                end else begin
                    sum_d[{idx_q, 1'b0} +: 2] = slice_s;
                    carry_d = slice_co;
                    if (idx_q == IDX_LAST) begin
                        cout_d  = slice_co;
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + IDXW'(1);
                        cnt_d      = '0;
                        slice_a_d  = a_dig[idx_d];
                        slice_b_d  = b_dig[idx_d];
                        slice_ci_d = slice_co;
                    end
                end
            end

            S_DONE: begin
                slice_a_d  = 2'b00;
                slice_b_d  = 2'b00;
                slice_ci_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            slice_a_q  <= 2'b00;
            slice_b_q  <= 2'b00;
            slice_ci_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            slice_a_q  <= slice_a_d;
            slice_b_q  <= slice_b_d;
            slice_ci_q <= slice_ci_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign slice_a  = slice_a_q;
    assign slice_b  = slice_b_q;
    assign slice_ci = slice_ci_q;

endmodule

// File: tb/tb_tma_serial_add_ctrl.sv
// Bench for tma_serial_add_ctrl: scoreboarded main instance with an ideal slice, plus two
// instances driving a 94-unit transport-delay slice to probe settle timing.
module tb_tma_serial_add_ctrl;

    localparam int W    = 8;
    localparam int S    = 1;
    localparam int NDIG = W / 2;
    localparam int LAT  = NDIG * S + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
    logic [1:0]   sl_a, sl_b, sl_s;
    logic         sl_ci, sl_co;

    logic         start_g, cin_g;
    logic [W-1:0] a_g, b_g;
    logic         busy10, done10, cout10, sci10;
    logic [W-1:0] sum10;
    logic [1:0]   sa10, sb10;
    logic [1:0]   ss10  = 2'b00;
    logic         sco10 = 1'b0;
    logic         busy9, done9, cout9, sci9;
    logic [W-1:0] sum9;
    logic [1:0]   sa9, sb9;
    logic [1:0]   ss9  = 2'b00;
    logic         sco9 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_left = 0;
    int n_txn = 0;
    logic [8:0] exp_q [$];

    logic [1:0] exp_sa  [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
    logic [1:0] exp_sb  [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
    logic       exp_sci [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    tma_serial_add_ctrl #(.WIDTH(W), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .slice_a(sl_a), .slice_b(sl_b), .slice_ci(sl_ci),
        .slice_s(sl_s), .slice_co(sl_co)
    );

    tma_serial_add_ctrl #(.WIDTH(W), .SETTLE(10)) u_slow10 (
        .clk(clk), .rst_n(rst_n), .start(start_g), .a(a_g), .b(b_g), .cin(cin_g),
        .busy(busy10), .done(done10), .sum(sum10), .cout(cout10),
        .slice_a(sa10), .slice_b(sb10), .slice_ci(sci10),
        .slice_s(ss10), .slice_co(sco10)
    );

    tma_serial_add_ctrl #(.WIDTH(W), .SETTLE(9)) u_slow9 (
        .clk(clk), .rst_n(rst_n), .start(start_g), .a(a_g), .b(b_g), .cin(cin_g),
        .busy(busy9), .done(done9), .sum(sum9), .cout(cout9),
        .slice_a(sa9), .slice_b(sb9), .slice_ci(sci9),
        .slice_s(ss9), .slice_co(sco9)
    );

    assign {sl_co, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {2'b00, sl_ci};

    // Transport delay: every input change lands on the outputs 94 units later, stale value until then.
    initial forever begin
        @(sa10 or sb10 or sci10);
        fork
            begin
                automatic logic [2:0] v = {1'b0, sa10} + {1'b0, sb10} + {2'b00, sci10};
                #94;
                {sco10, ss10} = v;
            end
        join_none
    end

    initial forever begin
        @(sa9 or sb9 or sci9);
        fork
            begin
                automatic logic [2:0] v = {1'b0, sa9} + {1'b0, sb9} + {2'b00, sci9};
                #94;
                {sco9, ss9} = v;
            end
        join_none
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        n_vec++;
        if (act === bad) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required any value but 0x%0h", name, act, bad);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_slice_a"}, sl_a, 0);
        check({tag, "_slice_b"}, sl_b, 0);
        check({tag, "_slice_ci"}, sl_ci, 0);
    endtask

    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [8:0] hand);
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        check($sformatf("held_%02h_%02h_%0b", av, bv, cv), {cout, sum}, hand);
    endtask

    // Reference timing model and scoreboard monitor.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_left = 0;
            exp_q.delete();
        end else if (m_left == 0) begin
            if (start) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
                m_left = LAT;
            end
        end else begin
            m_left--;
        end
        @(negedge clk);
        check("busy", busy, (m_left != 0));
        check("done", done, (m_left == 1));
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done_queue", 0, 1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: cycle %0d sum=0x%02h cout=%0b", n_txn, cyc, sum, cout);
                check("result", {cout, sum}, e);
            end
        end
    end

    initial begin
        int t10;
        int t9;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start_g = 1'b0; a_g = '0; b_g = '0; cin_g = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // A5 + 3C with a start pulse of 8'h11 injected mid-run
        start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDIG; i++) begin
            check($sformatf("t1_slice_a_%0d", i), sl_a, exp_sa[i]);
            check($sformatf("t1_slice_b_%0d", i), sl_b, exp_sb[i]);
            check($sformatf("t1_slice_ci_%0d", i), sl_ci, exp_sci[i]);
            if (i == 1) begin
                start = 1'b1; a = 8'h11; b = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("t1_done_hold_slice_a", sl_a, 2'b10);
        check("t1_done_hold_slice_ci", sl_ci, 1'b1);
        @(negedge clk);
        check("t1_idle_slice_a", sl_a, 2'b00);
        check("t1_idle_slice_ci", sl_ci, 1'b0);
        check("t1_result", {cout, sum}, 9'h0E1);

        op(8'hFF, 8'h01, 1'b0, 9'h100);
        op(8'hFF, 8'h00, 1'b1, 9'h100);
        op(8'h00, 8'h00, 1'b0, 9'h000);
        op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op(8'h55, 8'hAA, 1'b1, 9'h100);
        op(8'h12, 8'h34, 1'b0, 9'h046);

        // abort at digit 2
        start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_idx2_slice_a", sl_a, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);

        // back-to-back with operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 4 * (LAT + 1) + 1; i++) begin
            a = 8'(i * 37 + 5);
            b = 8'(i * 91 + 3);
            cin = i[0];
            @(negedge clk);
        end
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // slow slice: SETTLE=10 captures correctly, SETTLE=9 captures stale values
        start_g = 1'b1; a_g = 8'h7F; b_g = 8'h81; cin_g = 1'b0;
        @(negedge clk);
        start_g = 1'b0; a_g = '0; b_g = '0;
        t10 = 0;
        t9  = 0;
        for (int t = 1; t <= 60; t++) begin
            if (done10 && (t10 == 0)) begin
                t10 = t;
                check("s10_result", {cout10, sum10}, 9'h100);
            end
            if (done9 && (t9 == 0)) begin
                t9 = t;
                check_ne("s9_stale_capture", {cout9, sum9}, 9'h100);
            end
            @(negedge clk);
        end
        check("s10_latency", t10, 41);
        check("s9_latency", t9, 37);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
